// File: rtl/debouncer_sync_pkg.sv
// ============================================================================
// debouncer_sync_pkg
// Shared types and state encodings for the debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debouncer_sync_pkg;

  `include "debouncer_sync.vh"

  typedef logic [ST_W-1:0] state_t;

  // True for the two qualification states, where the counter is running.
  function automatic logic is_wait_state(input state_t st);
    return (st == ST_WAIT_HIGH) || (st == ST_WAIT_LOW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debouncer_sync.vh
// ============================================================================
// debouncer_sync.vh
// State encodings for the debouncer FSM, shared by the RTL and the bench.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEBOUNCER_SYNC_VH
`define DEBOUNCER_SYNC_VH

localparam int         ST_W         = 2;
localparam logic [1:0] ST_LOW       = 2'b00;
localparam logic [1:0] ST_WAIT_HIGH = 2'b01;
localparam logic [1:0] ST_HIGH      = 2'b11;
localparam logic [1:0] ST_WAIT_LOW  = 2'b10;

`endif

`default_nettype wire

// File: rtl/debouncer_sync_sync2ff.sv
// ============================================================================
// synchronizer_2ff
// Two back-to-back flops bringing an asynchronous bit into the clk domain.
// Nothing sits between the stages so the first flop gets a full cycle to
// resolve metastability.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronizer_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Pure wiring between stages; kept as _d nets so every flop has a named input.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchronizer stages, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

`default_nettype wire

// File: rtl/debouncer_sync.sv
// ============================================================================
// debouncer_sync
// Turns a bouncing asynchronous input into a clean synchronous level plus
// one-cycle rise/fall pulses. A new level must be seen STABLE_CYCLES
// consecutive synchronized cycles (after the cycle that entered qualification)
// before it is accepted.
// Optional feature: define DEBOUNCER_TOGGLE_EN to add the toggle output,
// a T flip-flop that inverts on every accepted rising edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer_sync
  import debouncer_sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic out_level,
  output logic rise,
  output logic fall
`ifdef DEBOUNCER_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 in_sync;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cnt_done;
  logic                 out_level_q, out_level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  synchronizer_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_raw),
    .q   (in_sync)
  );

  assign cnt_done = (cnt_q == CNT_LAST);

  // State and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter is cleared on every WAIT entry and only
  // advances while the candidate level is still present, so it stops at
  // CNT_LAST and can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (in_sync) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!in_sync)      state_d = ST_LOW;
        else if (cnt_done) state_d = ST_HIGH;
        else               cnt_d   = cnt_q + CNT_ONE;
      end
      ST_HIGH: begin
        if (!in_sync) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (in_sync)       state_d = ST_HIGH;
        else if (cnt_done) state_d = ST_LOW;
        else               cnt_d   = cnt_q + CNT_ONE;
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: level changes and pulses fire only on a completed qualification.
  always_comb begin
    out_level_d = out_level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    if (is_wait_state(state_q) && cnt_done) begin
      if ((state_q == ST_WAIT_HIGH) && in_sync) begin
        out_level_d = 1'b1;
        rise_d      = 1'b1;
      end
      if ((state_q == ST_WAIT_LOW) && !in_sync) begin
        out_level_d = 1'b0;
        fall_d      = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_level_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      out_level_q <= out_level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign out_level = out_level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

`ifdef DEBOUNCER_TOGGLE_EN
  logic toggle_q, toggle_d;

  // Flip in the same cycle the rise pulse is registered.
  always_comb begin
    toggle_d = toggle_q ^ rise_d;
  end

  // Toggle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_d;
  end

  assign toggle = toggle_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debouncer_sync.sv
// ============================================================================
// tb_debouncer_sync
// Directed bench for debouncer_sync (STABLE_CYCLES=4, 20 ns clock). Inputs
// change at posedge+5 and outputs are sampled at posedge+5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debouncer_sync;

  logic clk;
  logic rst;
  logic in_raw;
  logic out_level;
  logic rise;
  logic fall;
`ifdef DEBOUNCER_TOGGLE_EN
  logic toggle;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  debouncer_sync #(
    .STABLE_CYCLES (4),
    .CNT_WIDTH     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .out_level (out_level),
    .rise      (rise),
    .fall      (fall)
`ifdef DEBOUNCER_TOGGLE_EN
    ,
    .toggle    (toggle)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance to 5 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #5;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    in_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got out/rise/fall=%b%b%b want 000", e, out_level, rise, fall);
      end
`ifdef DEBOUNCER_TOGGLE_EN
      n_checks++;
      if (toggle !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_toggle cycle %0d: got %b want 0", e, toggle);
      end
`endif
    end
    in_raw = 1'b0;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_after_reset cycle %0d: got out/rise/fall=%b%b%b want 000", e, out_level, rise, fall);
      end
    end
  endtask

  task automatic test_glitch();
    in_raw = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) in_raw = 1'b0;
      n_checks++;
      if ({out_level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: got out/rise/fall=%b%b%b want 000", e, out_level, rise, fall);
      end
    end
  endtask

  task automatic test_clean_press();
    in_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== {(e >= 7), (e == 7), 1'b0}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got out/rise/fall=%b%b%b want %b%b0", e, out_level, rise, fall, (e >= 7), (e == 7));
      end
    end
  endtask

  task automatic test_release();
    in_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== {(e < 7), 1'b0, (e == 7)}) begin
        n_fail++;
        $display("FAIL release edge %0d: got out/rise/fall=%b%b%b want %b0%b", e, out_level, rise, fall, (e < 7), (e == 7));
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    int         rises;
    pattern = 4'b1010;
    rises   = 0;
    for (int i = 3; i >= 0; i--) begin
      in_raw = pattern[i];
      step();
      n_checks++;
      if ({out_level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_phase step %0d: got out/rise/fall=%b%b%b want 000", 3 - i, out_level, rise, fall);
      end
    end
    in_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (rise === 1'b1) rises++;
      n_checks++;
      if ({out_level, rise, fall} !== {(e >= 7), (e == 7), 1'b0}) begin
        n_fail++;
        $display("FAIL bounce_settle edge %0d: got out/rise/fall=%b%b%b want %b%b0", e, out_level, rise, fall, (e >= 7), (e == 7));
      end
    end
    n_checks++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_reset_mid_wait();
    in_raw = 1'b0;
    repeat (10) step();
    in_raw = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got out/rise/fall=%b%b%b want 000", out_level, rise, fall);
    end
    for (int e = 1; e <= 3; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_hold cycle %0d: got out/rise/fall=%b%b%b want 000", e, out_level, rise, fall);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if ({out_level, rise, fall} !== {(e >= 7), (e == 7), 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_requalify edge %0d: got out/rise/fall=%b%b%b want %b%b0", e, out_level, rise, fall, (e >= 7), (e == 7));
      end
    end
  endtask

`ifdef DEBOUNCER_TOGGLE_EN
  task automatic test_toggle();
    rst    = 1'b1;
    in_raw = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    n_checks++;
    if (toggle !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_initial: got %b want 0", toggle);
    end
    in_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if (toggle !== (e >= 7)) begin
        n_fail++;
        $display("FAIL toggle_press1 edge %0d: got %b want %b", e, toggle, (e >= 7));
      end
    end
    in_raw = 1'b0;
    repeat (10) step();
    n_checks++;
    if (toggle !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_after_release: got %b want 1", toggle);
    end
    in_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if (toggle !== (e < 7)) begin
        n_fail++;
        $display("FAIL toggle_press2 edge %0d: got %b want %b", e, toggle, (e < 7));
      end
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    in_raw = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_wait();
`ifdef DEBOUNCER_TOGGLE_EN
    test_toggle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
